float_accum_sched: RTL and testbench
====================================

Name: float_accum_sched

Overview:
- Sequences one float accumulator unit: issues `run`, holds `running`, and programs `strideMinusOne`/`delay0`.
- Pops contiguous groups of `cfg_len` elements from an upstream FIFO; the element data is wired straight from the FIFO to the accumulator `in0`.
- Captures each group's sum from the accumulator output exactly LAT cycles after the group's last element, into a 2-entry valid/ready result queue.
- Sits between the input FIFO, the accumulator, and the downstream consumer.

Parameters:
- LEN_W, 16, width of `cfg_len` and of the element counter; equals the accumulator STRIDE_W.
- CNT_W, 16, width of `cfg_groups` and of the group counter.
- LVL_W, 16, width of `in_level`.
- DELAY_W, 7, width of `acc_delay0`.
- LAT, 4, accumulator latency in cycles from input element to output.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- start, input, 1, single-cycle job start; honoured only in IDLE.
- cfg_len, input, LEN_W, elements per group; sampled at start.
- cfg_groups, input, CNT_W, number of groups; sampled at start.
- busy, output, 1, job in progress.
- done, output, 1, one-cycle pulse at job end.
- in_level, input, LVL_W, elements currently available upstream.
- in_pop, output, 1, consume one upstream element this cycle.
- acc_run, output, 1, accumulator run pulse.
- acc_running, output, 1, accumulator pipeline enable.
- acc_stride_minus_one, output, LEN_W, `len_q - 1`.
- acc_delay0, output, DELAY_W, constant 0.
- acc_out, input, 32, accumulator float result.
- res_data, output, 32, result float.
- res_last, output, 1, marks the result of the final group.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts the result.

Behaviour:
- Reset: async; clears FSM, counters, tag shift register and result queue. Every output is 0, except `acc_stride_minus_one`, which resets to all-ones. Reset mid-job abandons the job with no done pulse.
- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - start with `cfg_len == 0` or `cfg_groups == 0`: done pulses next cycle, no results, stay IDLE.
  - Otherwise latch `len_q` and `groups_q`, go to WAIT with busy = 1.
  - start while busy is ignored.
- Credit: free = 2 − queue_count − tags_in_flight. tags_in_flight includes a tag pushed this cycle. queue_count is the registered value; a same-cycle pop does not add credit.
- Group eligibility: `in_level >= len_q` and free ≥ 1.
- WAIT:
  - Group eligible: `acc_run = 1` this cycle, next state STREAM, element counter = 0.
  - Not eligible: stay in WAIT with acc_run = 0.
- STREAM:
  - `in_pop = 1` every cycle; the element counter increments.
  - Last-element cycle (`cnt == len_q - 1`): push a capture tag into the LAT-deep shift register, with its last flag = (final group), and increment the group count.
  - Final group: go to IDLE-drain, i.e. busy stays 1 until the tags empty.
  - More groups and eligible (evaluated this cycle, counting the new tag): stay in STREAM, counter = 0, no acc_run. The accumulator's free-running stride counter realigns naturally, so groups are back-to-back.
  - More groups, not eligible: go to WAIT, which re-issues acc_run.
- acc_running = busy OR (tag shift register nonzero); the tag shift register advances every cycle.
- Capture:
  - When a tag reaches stage LAT (cycle t+LAT for last element at cycle t), `acc_out` is written into the queue with its tag's last flag.
  - res_valid is asserted from cycle t+LAT+1.
  - The queue cannot overflow, by credit.
- Result queue: 2-entry FIFO; pops when `res_valid && res_ready`; `res_data`/`res_last` come from the head entry.
- Job end: on the capture cycle of the final tag, done pulses next cycle and busy drops with it. done does not wait for the queue to drain.
- Simultaneous push and pop on the queue is allowed; the count is unchanged.

Test Plan:
1. len=4, groups=2, in_level=16, every element 1.0 (0x3F800000), res_ready=1, start at cycle 0:
   - acc_run in cycle 1; in_pop in cycles 2–9 continuously.
   - res_valid with 0x40800000 in cycles 10 and 14; res_last=1 on the second.
   - done in cycle 14.
2. len=2, groups=1, elements −1.5, −1.5 → single result 0xC0400000, res_last=1.
3. len=4, groups=3, res_ready=0:
   - Two results queue; group 3 waits in WAIT with no acc_run.
   - Assert res_ready one cycle: the next cycle is eligible, acc_run fires, and the third result appears afterwards.
4. in_level=3 with len=4 → stays WAIT with in_pop=0; raising in_level to 4 → acc_run that cycle.
5. start with cfg_groups=0 → done pulses next cycle; no acc_run, no result, busy stays 0.
6. Assert rst mid-STREAM → all outputs 0 at once; a later start=1 job completes normally.

Source files
------------

// File: rtl/float_accum_sched.sv
// float_accum_sched
//   Sequences a single float accumulator. Pops groups of cfg_len elements
//   from an upstream FIFO (the data path bypasses this block and goes
//   straight to the accumulator input), then captures each group sum from
//   the accumulator output LAT cycles after the group's last element into a
//   2-entry valid/ready result queue.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     start, cfg_len,
//     cfg_groups               job start pulse and job shape (sampled at start)
//     busy, done               job in progress / one-cycle end-of-job pulse
//     in_level, in_pop         upstream FIFO occupancy and pop strobe
//     acc_run, acc_running,
//     acc_stride_minus_one,
//     acc_delay0, acc_out      accumulator control and result
//     res_data, res_last,
//     res_valid, res_ready     result stream to the consumer
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no group in flight; a drain flag keeps busy high while the
//          | final group's capture tag is still in the shift register
//   WAIT   | next group pending until enough input and result credit
//   STREAM | popping one element per cycle of the current group

module float_accum_sched #(
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int LVL_W   = 16,
    parameter int DELAY_W = 7,
    parameter int LAT     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_groups,
    output logic               busy,
    output logic               done,
    input  logic [LVL_W-1:0]   in_level,
    output logic               in_pop,
    output logic               acc_run,
    output logic               acc_running,
    output logic [LEN_W-1:0]   acc_stride_minus_one,
    output logic [DELAY_W-1:0] acc_delay0,
    input  logic [31:0]        acc_out,
    output logic [31:0]        res_data,
    output logic               res_last,
    output logic               res_valid,
    input  logic               res_ready
);

    localparam int CMP_W = (LVL_W > LEN_W) ? LVL_W : LEN_W;
    localparam int OCC_W = $clog2(LAT + 4) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t state, state_nx;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [CNT_W-1:0] groups_q;
    logic [CNT_W-1:0] grp_cnt;
    logic             drain;

    // Capture tags: bit 0 is stage 1, bit LAT-1 is the capture stage.
    logic [LAT-1:0]   tag_v;
    logic [LAT-1:0]   tag_last;

    logic [31:0]      q_data [2];
    logic [1:0]       q_last;
    logic             q_head;
    logic [1:0]       q_count;

    logic             last_elem;
    logic             final_grp;
    logic             push_tag;
    logic             capture;
    logic             cap_last;
    logic             q_pop;
    logic             q_wr;
    logic             eligible;
    logic             start_job;
    logic             zero_job;
    logic [OCC_W-1:0] occ;

    assign last_elem = (state == S_STREAM) && (cnt == len_q - 1'b1);
    assign final_grp = (grp_cnt == groups_q - 1'b1);
    assign push_tag  = last_elem;
    assign capture   = tag_v[LAT-1];
    assign cap_last  = tag_last[LAT-1];

    assign res_valid = (q_count != 2'd0);
    assign res_data  = q_data[q_head];
    assign res_last  = q_last[q_head];
    assign q_pop     = res_valid && res_ready;
    assign q_wr      = q_head ^ q_count[0];

    assign busy                 = (state != S_IDLE) || drain;
    assign acc_running          = busy || (tag_v != '0);
    assign acc_stride_minus_one = len_q - 1'b1;
    assign acc_delay0           = '0;

    // Result slots committed: queued entries plus every tag still in flight,
    // including one pushed this cycle. A pop this cycle gives no credit yet.
    always_comb begin
        occ = OCC_W'(q_count) + OCC_W'(push_tag);
        for (int i = 0; i < LAT; i++) begin
            occ = occ + OCC_W'(tag_v[i]);
        end
    end

    assign eligible = (CMP_W'(in_level) >= CMP_W'(len_q)) && (occ < OCC_W'(2));

    always_comb begin
        state_nx  = state;
        acc_run   = 1'b0;
        in_pop    = 1'b0;
        start_job = 1'b0;
        zero_job  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !drain) begin
                    if ((cfg_len == '0) || (cfg_groups == '0)) begin
                        zero_job = 1'b1;
                    end else begin
                        start_job = 1'b1;
                        state_nx  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (eligible) begin
                    acc_run  = 1'b1;
                    state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                in_pop = 1'b1;
                if (last_elem) begin
                    if (final_grp) begin
                        state_nx = S_IDLE;
                    end else if (!eligible) begin
                        state_nx = S_WAIT;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            groups_q <= '0;
            cnt      <= '0;
            grp_cnt  <= '0;
            drain    <= 1'b0;
            done     <= 1'b0;
            tag_v    <= '0;
            tag_last <= '0;
        end else begin
            state <= state_nx;
            done  <= zero_job || (capture && cap_last);

            if (start_job) begin
                len_q    <= cfg_len;
                groups_q <= cfg_groups;
                grp_cnt  <= '0;
            end else if (push_tag) begin
                grp_cnt <= grp_cnt + 1'b1;
            end

            // Back-to-back groups restart the count from the last-element cycle.
            if (acc_run) begin
                cnt <= '0;
            end else if (in_pop) begin
                cnt <= last_elem ? '0 : cnt + 1'b1;
            end

            if (push_tag && final_grp) begin
                drain <= 1'b1;
            end else if (capture && cap_last) begin
                drain <= 1'b0;
            end

            tag_v    <= (tag_v << 1) | LAT'(push_tag);
            tag_last <= (tag_last << 1) | LAT'(push_tag && final_grp);
        end
    end

    // Credit accounting guarantees a capture never lands on a full queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                q_data[i] <= '0;
            end
            q_last  <= '0;
            q_head  <= 1'b0;
            q_count <= '0;
        end else begin
            if (capture) begin
                q_data[q_wr] <= acc_out;
                q_last[q_wr] <= cap_last;
            end
            if (q_pop) begin
                q_head <= ~q_head;
            end
            q_count <= q_count + 2'(capture) - 2'(q_pop);
        end
    end

endmodule

// File: tb/tb_float_accum_sched.sv
module tb_float_accum_sched;

    localparam int LEN_W   = 16;
    localparam int CNT_W   = 16;
    localparam int LVL_W   = 16;
    localparam int DELAY_W = 7;
    localparam int LAT     = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_groups;
    logic               busy;
    logic               done;
    logic [LVL_W-1:0]   in_level;
    logic               in_pop;
    logic               acc_run;
    logic               acc_running;
    logic [LEN_W-1:0]   acc_stride_minus_one;
    logic [DELAY_W-1:0] acc_delay0;
    logic [31:0]        acc_out;
    logic [31:0]        res_data;
    logic               res_last;
    logic               res_valid;
    logic               res_ready;

    always #5 clk = ~clk;

    float_accum_sched #(
        .LEN_W(LEN_W), .CNT_W(CNT_W), .LVL_W(LVL_W), .DELAY_W(DELAY_W), .LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_groups(cfg_groups),
        .busy(busy), .done(done), .in_level(in_level), .in_pop(in_pop),
        .acc_run(acc_run), .acc_running(acc_running),
        .acc_stride_minus_one(acc_stride_minus_one), .acc_delay0(acc_delay0),
        .acc_out(acc_out), .res_data(res_data), .res_last(res_last),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Element values are halves: k stands for k/2, exact in single precision.
    function automatic logic [31:0] half_to_float(input int k);
        int mag;
        int p;
        logic [31:0] m;
        if (k == 0) return 32'h0;
        mag = (k < 0) ? -k : k;
        p = 0;
        for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
        m = 32'(mag) << (23 - p);
        return {(k < 0), 8'(p + 126), m[22:0]};
    endfunction

    // Environment: upstream FIFO, accumulator model, result scoreboard.
    int          fifo[$];
    int          src[$];
    int          exp_q[$];
    bit          exp_last[$];
    logic [31:0] hist[8];
    int          cur_len;
    int          committed;
    int          run_sum;
    int          eidx;
    int          cyc;
    int          t0;
    int          n_run, n_pop, n_done, n_res;
    bit          level_override;
    int          level_force;
    int          supply_max;
    bit          rand_ready;
    logic [31:0] last_res_data;

    bit          run_log[64], pop_log[64], vld_log[64], done_log[64], busy_log[64], last_log[64];
    logic [31:0] data_log[64];

    task automatic clear_env();
        fifo.delete(); src.delete(); exp_q.delete(); exp_last.delete();
        committed = 0; eidx = 0; run_sum = 0;
        for (int i = 0; i < 8; i++) hist[i] = 32'h7FC0_0000 | 32'(i);
    endtask

    // One clock cycle: entered and left #1 after a rising edge.
    task automatic cycle_step();
        int n;
        int lv;
        int e;
        int rel;
        if (supply_max > 0) begin
            n = int'($urandom_range(supply_max, 0));
            while (n > 0 && src.size() > 0) begin
                fifo.push_back(src.pop_front());
                n--;
            end
        end
        if (rand_ready) res_ready = 1'($urandom_range(1, 0));
        // Level is reported net of elements already committed to the group in progress.
        lv = level_override ? level_force : (fifo.size() - committed);
        if (lv < 0) lv = 0;
        in_level = LVL_W'(lv);
        acc_out  = hist[(cyc - LAT) & 7];
        @(negedge clk);
        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
            run_log[rel]  = acc_run;
            pop_log[rel]  = in_pop;
            vld_log[rel]  = res_valid;
            done_log[rel] = done;
            busy_log[rel] = busy;
            last_log[rel] = res_last;
            data_log[rel] = res_data;
        end
        hist[cyc & 7] = 32'h7FC0_0000 | 32'(cyc & 16'hFFFF);
        if (acc_run) begin
            n_run++;
            committed = cur_len;
            eidx = 0;
        end
        if (in_pop) begin
            n_pop++;
            check_eq("underflow", 32'(fifo.size() > 0), 1);
            e = (fifo.size() > 0) ? fifo.pop_front() : 0;
            if (committed == 0) committed = cur_len;
            committed--;
            run_sum = (eidx == 0) ? e : run_sum + e;
            eidx++;
            if (eidx == cur_len) begin
                eidx = 0;
                hist[cyc & 7] = half_to_float(run_sum);
            end
        end
        if (res_valid && res_ready) begin
            n_res++;
            last_res_data = res_data;
            check_eq("result_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check_eq("res_data", res_data, half_to_float(exp_q.pop_front()));
                check_eq("res_last", res_last, exp_last.pop_front());
            end
        end
        if (done) n_done++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic prepare_job(input int len, input int groups, input int lo, input int hi,
                               input bit to_fifo);
        int e;
        int s;
        for (int g = 0; g < groups; g++) begin
            s = 0;
            for (int i = 0; i < len; i++) begin
                e = lo + int'($urandom_range(hi - lo));
                s += e;
                if (to_fifo) fifo.push_back(e);
                else src.push_back(e);
            end
            exp_q.push_back(s);
            exp_last.push_back(g == groups - 1);
        end
    endtask

    task automatic pulse_start(input int len, input int groups);
        for (int i = 0; i < 64; i++) begin
            run_log[i] = 0; pop_log[i] = 0; vld_log[i] = 0;
            done_log[i] = 0; busy_log[i] = 0; last_log[i] = 0; data_log[i] = '0;
        end
        n_run = 0; n_pop = 0; n_done = 0; n_res = 0;
        cur_len    = len;
        cfg_len    = LEN_W'(len);
        cfg_groups = CNT_W'(groups);
        start      = 1'b1;
        t0         = cyc;
        cycle_step();
        start      = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int b;
        b = budget;
        while (n_done == 0 && b > 0) begin
            cycle_step();
            b--;
        end
        check_eq("done_seen", n_done, 1);
    endtask

    task automatic drain_results(input int budget);
        int b;
        b = budget;
        rand_ready = 1'b0;
        res_ready  = 1'b1;
        while (exp_q.size() > 0 && b > 0) begin
            cycle_step();
            b--;
        end
        check_eq("results_drained", exp_q.size(), 0);
    endtask

    initial begin
        int p;
        int len;
        int groups;
        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_groups = '0;
        in_level = '0; acc_out = '0; res_ready = 1'b0;
        level_override = 0; level_force = 0; supply_max = 0; rand_ready = 0;
        cur_len = 1; cyc = 16; t0 = 0; last_res_data = '0;
        n_run = 0; n_pop = 0; n_done = 0; n_res = 0;
        clear_env();

        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_in_pop", in_pop, 0);
        check_eq("rst_acc_run", acc_run, 0);
        check_eq("rst_acc_running", acc_running, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_last", res_last, 0);
        check_eq("rst_stride", acc_stride_minus_one, 32'h0000_FFFF);
        check_eq("rst_delay0", acc_delay0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: two back-to-back groups of four 1.0 elements
        level_override = 1; level_force = 16; res_ready = 1'b1;
        prepare_job(4, 2, 2, 2, 1);
        pulse_start(4, 2);
        repeat (20) cycle_step();
        check_eq("t1_run_c1", run_log[1], 1);
        check_eq("t1_run_count", n_run, 1);
        p = 0;
        for (int i = 2; i <= 9; i++) p += int'(pop_log[i]);
        check_eq("t1_pop_c2_9", p, 8);
        check_eq("t1_pop_total", n_pop, 8);
        check_eq("t1_vld_c10", vld_log[10], 1);
        check_eq("t1_data_c10", data_log[10], 32'h4080_0000);
        check_eq("t1_last_c10", last_log[10], 0);
        check_eq("t1_vld_c11", vld_log[11], 0);
        check_eq("t1_vld_c14", vld_log[14], 1);
        check_eq("t1_data_c14", data_log[14], 32'h4080_0000);
        check_eq("t1_last_c14", last_log[14], 1);
        check_eq("t1_done_c13", done_log[13], 0);
        check_eq("t1_done_c14", done_log[14], 1);
        check_eq("t1_done_count", n_done, 1);
        check_eq("t1_busy_c13", busy_log[13], 1);
        check_eq("t1_busy_c14", busy_log[14], 0);
        check_eq("t1_results", n_res, 2);
        level_override = 0;

        // 2: single group, -1.5 + -1.5
        prepare_job(2, 1, -3, -3, 1);
        pulse_start(2, 1);
        run_until_done(50);
        drain_results(20);
        check_eq("t2_result", last_res_data, 32'hC040_0000);
        check_eq("t2_results", n_res, 1);

        // 3: consumer stalled, third group held back by credit
        res_ready = 1'b0;
        prepare_job(4, 3, -4, 6, 1);
        pulse_start(4, 3);
        repeat (5) cycle_step();
        cfg_groups = '0; start = 1'b1;
        cycle_step();
        start = 1'b0;
        repeat (19) cycle_step();
        check_eq("t3_res_valid", res_valid, 1);
        check_eq("t3_busy", busy, 1);
        check_eq("t3_run_count", n_run, 1);
        check_eq("t3_pop_count", n_pop, 8);
        check_eq("t3_start_ignored", n_done, 0);
        res_ready = 1'b1;
        cycle_step();
        res_ready = 1'b0;
        check_eq("t3_no_run_on_pop", n_run, 1);
        cycle_step();
        check_eq("t3_run_after_ready", n_run, 2);
        res_ready = 1'b1;
        run_until_done(100);
        drain_results(20);
        check_eq("t3_results", n_res, 3);
        check_eq("t3_pop_total", n_pop, 12);

        // 4: level one short, then enough
        prepare_job(4, 1, -8, 8, 1);
        src.push_back(fifo.pop_back());
        pulse_start(4, 1);
        repeat (5) cycle_step();
        check_eq("t4_wait_no_run", n_run, 0);
        check_eq("t4_wait_no_pop", n_pop, 0);
        check_eq("t4_wait_busy", busy, 1);
        fifo.push_back(src.pop_front());
        cycle_step();
        check_eq("t4_run_on_level", n_run, 1);
        check_eq("t4_no_pop_yet", n_pop, 0);
        run_until_done(50);
        drain_results(20);

        // 5: empty jobs
        pulse_start(4, 0);
        check_eq("t5_done_next", done, 1);
        check_eq("t5_busy", busy, 0);
        cycle_step();
        check_eq("t5_done_pulse", done, 0);
        repeat (3) cycle_step();
        check_eq("t5_no_run", n_run, 0);
        check_eq("t5_no_result", n_res, 0);
        check_eq("t5_res_valid", res_valid, 0);
        check_eq("t5_done_count", n_done, 1);
        pulse_start(0, 3);
        check_eq("t5_len0_done", done, 1);

        // 6: reset in the middle of streaming
        res_ready = 1'b1;
        prepare_job(4, 2, -8, 8, 1);
        pulse_start(4, 2);
        repeat (3) cycle_step();
        check_eq("t6_in_stream", in_pop, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_busy", busy, 0);
        check_eq("t6_in_pop", in_pop, 0);
        check_eq("t6_acc_run", acc_run, 0);
        check_eq("t6_acc_running", acc_running, 0);
        check_eq("t6_res_valid", res_valid, 0);
        check_eq("t6_res_data", res_data, 0);
        check_eq("t6_done", done, 0);
        check_eq("t6_stride", acc_stride_minus_one, 32'h0000_FFFF);
        rst = 1'b0;
        clear_env();
        @(posedge clk);
        #1;
        cyc++;
        check_eq("t6_no_done", done, 0);
        prepare_job(3, 2, -8, 8, 1);
        pulse_start(3, 2);
        run_until_done(60);
        drain_results(20);
        check_eq("t6_results", n_res, 2);

        // Randomized jobs with trickled input and a random consumer
        for (int j = 0; j < 20; j++) begin
            len    = int'($urandom_range(6, 1));
            groups = int'($urandom_range(4, 1));
            prepare_job(len, groups, -8, 8, 0);
            supply_max = int'($urandom_range(3, 1));
            rand_ready = 1'b1;
            pulse_start(len, groups);
            run_until_done(2000);
            drain_results(200);
            check_eq("rnd_pop_total", n_pop, len * groups);
            check_eq("rnd_fifo_empty", fifo.size() + src.size(), 0);
            supply_max = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
